multiway_matcher: RTL
=====================

# multiway_matcher

Parametrised exact-match lookup stage for the switch pipeline. On `start_i` it pulls a configurable key (header base + offset, up to `MAX_KEY_BYTES` bytes) byte-by-byte from shared memory and hashes it through the existing `hash` unit. It then probes a `WAYS`-way bucket of valid-tagged entries, with early abort on the first mismatching byte. It returns hit/miss, the matching way and the value address, and keeps saturating hit/miss counters; runtime reconfiguration is accepted only while idle.

## Interface
- `NUM_HEADERS`, 2: number of 32-bit header base addresses in `parsed_hdrs_i`.
- `MAX_KEY_BYTES`, 8: key bytes supported; ≤ 8 (hash key is 64 bits).
- `WAYS`, 4: entries per bucket, ≥ 1.
- `ENTRY_LEN`, 16: bytes per entry; ≥ 1 + `MAX_KEY_BYTES`.
- `BUCKET_BITS`, 6: hash bits used as bucket index.
- `TABLE_BASE`, 128: byte address of bucket 0.
- `clk`  input  1  clock.
- `rst`  input  1  reset; asynchronous, active-low.
- `start_i`  input  1  lookup request, level; held until `ready_o` is seen.
- `parsed_hdrs_i`  input  32*NUM_HEADERS  header base addresses; header 0 in the MSBs.
- `mem_ce_o`, `mem_we_o`  output  1 each  memory enable, write enable (`mem_we_o` tied 0).
- `mem_addr_o`  output  32  byte address.
- `mem_width_o`  output  4  tied 1.
- `mem_data_o`  output  32  tied 0.
- `mem_data_i`  input  32  read data; byte in [7:0], valid in the same cycle as `mem_addr_o`.
- `ready_o`  output  1  result valid.
- `hit_o`  output  1  match found.
- `way_o`  output  clog2(WAYS) (min 1)  matching way.
- `val_addr_o`  output  32  value address on hit; 0 on miss.
- `hit_cnt_o`, `miss_cnt_o`  output  32 each  saturating lookup counters.
- `mod_start_i`  input  1  config write strobe.
- `mod_match_hdr_id_i` (4), `mod_match_key_off_i` (6), `mod_match_key_len_i` (6)  input  new config.
- `mod_ack_o`, `mod_err_o`  output  1 each  one-cycle config accept / reject pulses.

## Operation
- Reset (async assert, sync release) sets every output to 0, the config to 0/0/0 and the state to FREE. The internal `hash` instance receives an active-high reset derived as `~rst`.
- **FREE**
  - `mod_start_i` has priority. If `hdr_id < NUM_HEADERS`, the config is latched and `mod_ack_o` pulses; otherwise the config is unchanged and `mod_err_o` pulses.
  - `mod_start_i` is ignored outside FREE, with no ack and no err.
  - `start_i` with no `mod_start_i`: `ready_o`, `hit_o` and `val_addr_o` clear, key registers zero, `mem_addr` = `parsed_hdrs[hdr_id] + key_off` (32-bit wrap), and the state goes to LOAD_KEY.
  - Effective key length L = min(key_len, MAX_KEY_BYTES).
- **LOAD_KEY**
  - Byte i (0..L-1) is captured from `mem_data_i[7:0]` while `mem_addr_o` = base+i, with `mem_ce_o` = 1.
  - After L bytes: `mem_ce_o` = 0, `hash_start` asserts and the state goes to HASH.
  - The hash key packs byte 0 into [63:56]; unused bytes are 0.
- **HASH**
  - Wait for `hash_ready`, then drop `hash_start`.
  - b = `hash_val[BUCKET_BITS-1:0]`; bucket address = TABLE_BASE + b*WAYS*ENTRY_LEN; way w = 0.
- **PROBE_VALID**
  - Read the byte at entry base E = bucket + w*ENTRY_LEN.
  - Nonzero: go to PROBE_KEY (or straight to a hit if L = 0).
  - Zero: go to the next way, or to a miss after way WAYS-1.
- **PROBE_KEY**
  - Read E+1+j and compare it with key byte j.
  - On mismatch, abort this way immediately and move to the next way (or a miss).
  - If all L bytes match: hit, `val_addr_o` = E+1+L, `way_o` = w.
- **DONE**
  - `mem_ce_o` = 0 and `ready_o` = 1; `hit_o`, `way_o` and `val_addr_o` are stable.
  - Exactly one of the counters increments (saturating at 0xFFFFFFFF) on entry to DONE.
  - When `start_i` = 0: `ready_o` drops and the state goes to FREE.
- Any illegal state encoding returns to FREE.

## Timing
- One memory read per cycle; `mem_ce_o` = 1 only during LOAD_KEY reads and PROBE reads.
- LOAD_KEY occupies L+1 cycles.
- HASH occupies the hash unit latency plus 1 cycle.
- Each way costs 1 cycle (invalid), 1+k cycles (mismatch at byte k, 1 ≤ k ≤ L), or 1+L cycles (hit).
- The transition into DONE takes 1 cycle.
- `ready_o` rises on the first cycle of DONE.
- A new lookup needs `start_i` low for ≥ 1 cycle after `ready_o`.
- Simultaneous `mod_start_i` and `start_i` in FREE: config is applied that cycle, and the lookup starts the next cycle with the new config.
- Reset asserted mid-lookup aborts immediately, with all outputs 0 and counters cleared.

## Test plan
- **Config accept/reject:** mod {hdr 1, off 4, len 2} -> `mod_ack_o` 1 cycle. Then hdr 5 -> `mod_err_o` 1 cycle with config unchanged. mod while in LOAD_KEY -> no pulse.
- **Hit in way 2:**
  - Setup: hdrs {0x40, 0x60}, config {1, 4, 2}, mem[0x64..65] = AA BB.
  - Bucket b is taken from the hash model; ways 0/1 are invalid and way 2 is valid AA BB.
  - Required: `hit_o` = 1, `way_o` = 2, `val_addr_o` = 128 + b*64 + 35, `hit_cnt_o` = 1.
- **Miss with early abort:** way 0 valid AA CC, others invalid -> way 0 probe takes 3 cycles, `hit_o` = 0, `val_addr_o` = 0, `miss_cnt_o` +1.
- **key_len 0 and clamp:**
  - len 0 with way 0 valid -> hit, `val_addr_o` = E+1, no LOAD_KEY reads.
  - len 12 -> exactly 8 key reads.
- **Handshake:** `start_i` held 10 cycles past `ready_o` -> single counter increment, `ready_o` held; `start_i` low -> `ready_o` 0 the next cycle.
- **Reset mid-probe:** assert `rst` = 0 in PROBE_KEY -> all outputs 0 asynchronously; after release a lookup completes normally.

Source files
------------

// File: rtl/multiway_matcher.sv
// Exact-match lookup: loads a key from a parsed header, hashes it, then probes a
// WAYS-way bucket of valid-tagged entries, aborting each way on its first mismatching byte.

// Two-stage key hash; ready is held while start stays high.
module hash (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  output logic        ready,
  output logic [31:0] val
);
  logic        busy;
  logic [31:0] fold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      ready  <= 1'b0;
      fold_q <= '0;
      val    <= '0;
    end else if (!start) begin
      busy  <= 1'b0;
      ready <= 1'b0;
    end else if (!busy && !ready) begin
      fold_q <= key[63:32] ^ key[31:0];
      busy   <= 1'b1;
    end else if (busy) begin
      val   <= fold_q ^ (fold_q >> 8) ^ (fold_q >> 16);
      ready <= 1'b1;
      busy  <= 1'b0;
    end
  end
endmodule

// state       | meaning
// S_FREE      | idle; accepts config writes and lookup requests
// S_LOAD      | reading key bytes from the header, one per cycle
// S_HASH      | waiting for the hash unit
// S_PVALID    | reading the valid byte of the current way
// S_PKEY      | comparing stored key bytes of the current way
// S_FINISH    | result settled; counters update on the way out
// S_DONE      | ready_o high until start_i drops
module multiway_matcher #(
  parameter int NUM_HEADERS   = 2,
  parameter int MAX_KEY_BYTES = 8,
  parameter int WAYS          = 4,
  parameter int ENTRY_LEN     = 16,
  parameter int BUCKET_BITS   = 6,
  parameter int TABLE_BASE    = 128,
  localparam int WAY_W        = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [32*NUM_HEADERS-1:0] parsed_hdrs_i,
  output logic                      mem_ce_o,
  output logic                      mem_we_o,
  output logic [31:0]               mem_addr_o,
  output logic [3:0]                mem_width_o,
  output logic [31:0]               mem_data_o,
  input  logic [31:0]               mem_data_i,
  output logic                      ready_o,
  output logic                      hit_o,
  output logic [WAY_W-1:0]          way_o,
  output logic [31:0]               val_addr_o,
  output logic [31:0]               hit_cnt_o,
  output logic [31:0]               miss_cnt_o,
  input  logic                      mod_start_i,
  input  logic [3:0]                mod_match_hdr_id_i,
  input  logic [5:0]                mod_match_key_off_i,
  input  logic [5:0]                mod_match_key_len_i,
  output logic                      mod_ack_o,
  output logic                      mod_err_o
);
  localparam logic [2:0] S_FREE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_HASH   = 3'd2;
  localparam logic [2:0] S_PVALID = 3'd3;
  localparam logic [2:0] S_PKEY   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]       state;
  logic [3:0]       cfg_hdr;
  logic [5:0]       cfg_off;
  logic [5:0]       cfg_len;
  logic [63:0]      key_q;
  logic [3:0]       idx;
  logic [WAY_W-1:0] way_q;
  logic [31:0]      ent_q;
  logic             hash_start;
  logic             hash_ready;
  logic [31:0]      hash_val;
  logic [3:0]       eff_len;
  logic [31:0]      hdr_base;
  logic [7:0]       key_byte;
  logic [31:0]      bucket_addr;
  logic             last_way;
  logic [7:0]       rd_byte;
  logic             unused_ok;

  assign mem_we_o    = 1'b0;
  assign mem_width_o = 4'd1;
  assign mem_data_o  = 32'd0;
  assign rd_byte     = mem_data_i[7:0];
  assign unused_ok   = ^{mem_data_i[31:8], hash_val[31:BUCKET_BITS]};

  assign eff_len  = (cfg_len > 6'(MAX_KEY_BYTES)) ? 4'(MAX_KEY_BYTES) : cfg_len[3:0];
  assign last_way = (way_q == WAY_W'(WAYS - 1));
  assign mem_ce_o = ((state == S_LOAD) && (idx != eff_len)) ||
                    (state == S_PVALID) || (state == S_PKEY);
  assign bucket_addr = 32'(TABLE_BASE) +
                       32'(hash_val[BUCKET_BITS-1:0]) * 32'(WAYS * ENTRY_LEN);

  always_comb begin
    hdr_base = '0;
    for (int h = 0; h < NUM_HEADERS; h++)
      if (cfg_hdr == 4'(h)) hdr_base = parsed_hdrs_i[32*(NUM_HEADERS-1-h) +: 32];
  end

  always_comb begin
    key_byte = '0;
    for (int i = 0; i < 8; i++)
      if (idx == 4'(i)) key_byte = key_q[63-8*i -: 8];
  end

  hash u_hash (
    .clk   (clk),
    .rst   (~rst),
    .start (hash_start),
    .key   (key_q),
    .ready (hash_ready),
    .val   (hash_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FREE;
      cfg_hdr    <= '0;
      cfg_off    <= '0;
      cfg_len    <= '0;
      key_q      <= '0;
      idx        <= '0;
      way_q      <= '0;
      ent_q      <= '0;
      hash_start <= 1'b0;
      mem_addr_o <= '0;
      ready_o    <= 1'b0;
      hit_o      <= 1'b0;
      way_o      <= '0;
      val_addr_o <= '0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      mod_ack_o  <= 1'b0;
      mod_err_o  <= 1'b0;
    end else begin
      mod_ack_o <= 1'b0;
      mod_err_o <= 1'b0;
      case (state)
        S_FREE: begin
          if (mod_start_i) begin
            if (mod_match_hdr_id_i < 4'(NUM_HEADERS)) begin
              cfg_hdr   <= mod_match_hdr_id_i;
              cfg_off   <= mod_match_key_off_i;
              cfg_len   <= mod_match_key_len_i;
              mod_ack_o <= 1'b1;
            end else begin
              mod_err_o <= 1'b1;
            end
          end else if (start_i) begin
            ready_o    <= 1'b0;
            hit_o      <= 1'b0;
            val_addr_o <= '0;
            key_q      <= '0;
            idx        <= '0;
            mem_addr_o <= hdr_base + 32'(cfg_off);
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (idx != eff_len) begin
            for (int i = 0; i < 8; i++)
              if (idx == 4'(i)) key_q[63-8*i -: 8] <= rd_byte;
            idx        <= idx + 4'd1;
            mem_addr_o <= mem_addr_o + 32'd1;
          end else begin
            hash_start <= 1'b1;
            state      <= S_HASH;
          end
        end
        S_HASH: begin
          if (hash_ready) begin
            hash_start <= 1'b0;
            way_q      <= '0;
            ent_q      <= bucket_addr;
            mem_addr_o <= bucket_addr;
            state      <= S_PVALID;
          end
        end
        S_PVALID: begin
          if (rd_byte != 8'd0) begin
            if (eff_len == 4'd0) begin
              hit_o      <= 1'b1;
              way_o      <= way_q;
              val_addr_o <= ent_q + 32'd1;
              state      <= S_FINISH;
            end else begin
              idx        <= '0;
              mem_addr_o <= ent_q + 32'd1;
              state      <= S_PKEY;
            end
          end else if (last_way) begin
            state <= S_FINISH;
          end else begin
            way_q      <= way_q + 1'b1;
            ent_q      <= ent_q + 32'(ENTRY_LEN);
            mem_addr_o <= ent_q + 32'(ENTRY_LEN);
          end
        end
        S_PKEY: begin
          // A mismatch abandons this way at once rather than reading the rest of its key.
          if (rd_byte != key_byte) begin
            if (last_way) begin
              state <= S_FINISH;
            end else begin
              way_q      <= way_q + 1'b1;
              ent_q      <= ent_q + 32'(ENTRY_LEN);
              mem_addr_o <= ent_q + 32'(ENTRY_LEN);
              state      <= S_PVALID;
            end
          end else if (idx == eff_len - 4'd1) begin
            hit_o      <= 1'b1;
            way_o      <= way_q;
            val_addr_o <= ent_q + 32'd1 + 32'(eff_len);
            state      <= S_FINISH;
          end else begin
            idx        <= idx + 4'd1;
            mem_addr_o <= mem_addr_o + 32'd1;
          end
        end
        S_FINISH: begin
          ready_o <= 1'b1;
          if (hit_o) begin
            if (hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
          end else begin
            if (miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          if (!start_i) begin
            ready_o <= 1'b0;
            state   <= S_FREE;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end
endmodule
